// File: rtl/writeback_if.sv
// Bundle between the MEM/decode side of the pipeline and the writeback stage.
// The master drives instruction, control and register-file read signals; the slave is the WB stage.
interface writeback_if;
  logic        mem_valid;
  logic        mem_reg_we;
  logic [4:0]  mem_rd_addr;
  logic [1:0]  mem_wb_sel;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_pc;
  logic [31:0] mem_load_data;
  logic [2:0]  mem_funct3;
  logic        stall;
  logic        flush;
  logic [4:0]  dec_rs1_addr;
  logic [4:0]  dec_rs2_addr;
  logic [31:0] rf_rs1_data;
  logic [31:0] rf_rs2_data;

  logic        write_enable;
  logic [4:0]  addr_rd;
  logic [31:0] data_rd;
  logic        wb_valid;
  logic        load_fault;
  logic [31:0] retire_count;
  logic [31:0] fwd_rs1_data;
  logic [31:0] fwd_rs2_data;

  modport master (
    output mem_valid, mem_reg_we, mem_rd_addr, mem_wb_sel, mem_alu_result,
           mem_pc, mem_load_data, mem_funct3, stall, flush,
           dec_rs1_addr, dec_rs2_addr, rf_rs1_data, rf_rs2_data,
    input  write_enable, addr_rd, data_rd, wb_valid, load_fault,
           retire_count, fwd_rs1_data, fwd_rs2_data
  );

  modport slave (
    input  mem_valid, mem_reg_we, mem_rd_addr, mem_wb_sel, mem_alu_result,
           mem_pc, mem_load_data, mem_funct3, stall, flush,
           dec_rs1_addr, dec_rs2_addr, rf_rs1_data, rf_rs2_data,
    output write_enable, addr_rd, data_rd, wb_valid, load_fault,
           retire_count, fwd_rs1_data, fwd_rs2_data
  );
endinterface

// File: rtl/writeback_stage.sv
// Pipeline writeback stage: WB register, load extraction/fault check, retire counter.
// Define WB_BYPASS_EN to forward the in-flight WB write to the decode operands.
module writeback_stage (
  input  logic        clk,
  input  logic        rst_n,
  writeback_if.slave  wb
);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic        valid_q;
  logic        reg_we_q;
  logic [4:0]  rd_q;
  logic [1:0]  wb_sel_q;
  logic [31:0] alu_q;
  logic [31:0] pc_q;
  logic [31:0] ld_data_q;
  logic [2:0]  funct3_q;
  logic [31:0] retire_count_q;
  logic [31:0] retire_count_d;

  logic [1:0]  offset;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;
  logic        ld_bad;
  logic        fault;
  logic        we;
  logic [31:0] data;

  assign retire_count_d = (valid_q && !wb.stall && !wb.flush) ? retire_count_q + 32'd1
                                                              : retire_count_q;

  // Flush only drops the valid bit; the stale payload is harmless once valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q        <= 1'b0;
      reg_we_q       <= 1'b0;
      rd_q           <= 5'd0;
      wb_sel_q       <= 2'b00;
      alu_q          <= 32'd0;
      pc_q           <= 32'd0;
      ld_data_q      <= 32'd0;
      funct3_q       <= 3'd0;
      retire_count_q <= 32'd0;
    end else begin
      retire_count_q <= retire_count_d;
      if (wb.flush) begin
        valid_q <= 1'b0;
      end else if (!wb.stall) begin
        valid_q   <= wb.mem_valid;
        reg_we_q  <= wb.mem_reg_we;
        rd_q      <= wb.mem_rd_addr;
        wb_sel_q  <= wb.mem_wb_sel;
        alu_q     <= wb.mem_alu_result;
        pc_q      <= wb.mem_pc;
        ld_data_q <= wb.mem_load_data;
        funct3_q  <= wb.mem_funct3;
      end
    end
  end

  assign offset  = alu_q[1:0];
  assign ld_half = offset[1] ? ld_data_q[31:16] : ld_data_q[15:0];

  always_comb begin
    ld_byte = ld_data_q[7:0];
    case (offset)
      2'd1:    ld_byte = ld_data_q[15:8];
      2'd2:    ld_byte = ld_data_q[23:16];
      2'd3:    ld_byte = ld_data_q[31:24];
      default: ld_byte = ld_data_q[7:0];
    endcase
  end

  always_comb begin
    ld_val = 32'd0;
    ld_bad = 1'b0;
    case (funct3_q)
      F3_LB:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      F3_LH: begin
        ld_val = {{16{ld_half[15]}}, ld_half};
        ld_bad = offset[0];
      end
      F3_LW: begin
        ld_val = ld_data_q;
        ld_bad = (offset != 2'd0);
      end
      F3_LBU: ld_val = {24'd0, ld_byte};
      F3_LHU: begin
        ld_val = {16'd0, ld_half};
        ld_bad = offset[0];
      end
      default: ld_bad = 1'b1;
    endcase
  end

  assign fault = valid_q && (wb_sel_q == SEL_LOAD) && ld_bad;

  always_comb begin
    data = 32'd0;
    case (wb_sel_q)
      SEL_ALU:  data = alu_q;
      SEL_LOAD: data = ld_bad ? 32'd0 : ld_val;
      SEL_PC4:  data = pc_q + 32'd4;
      default:  data = 32'd0;
    endcase
  end

  // The reserved select never writes, so it is excluded alongside x0 and faults.
  assign we = valid_q && reg_we_q && (rd_q != 5'd0) && !fault && (wb_sel_q != 2'b11);

  assign wb.write_enable = we;
  assign wb.addr_rd      = rd_q;
  assign wb.data_rd      = data;
  assign wb.wb_valid     = valid_q;
  assign wb.load_fault   = fault;
  assign wb.retire_count = retire_count_q;

`ifdef WB_BYPASS_EN
  assign wb.fwd_rs1_data = (we && (wb.dec_rs1_addr == rd_q)) ? data : wb.rf_rs1_data;
  assign wb.fwd_rs2_data = (we && (wb.dec_rs2_addr == rd_q)) ? data : wb.rf_rs2_data;
`else
  logic unused_dec_addr;
  assign unused_dec_addr = ^{wb.dec_rs1_addr, wb.dec_rs2_addr};
  assign wb.fwd_rs1_data = wb.rf_rs1_data;
  assign wb.fwd_rs2_data = wb.rf_rs2_data;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: load extension/faults, x0, stall/flush, bypass,
// retire counter wrap and asynchronous reset.
module tb_writeback_stage;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  writeback_if wb_if ();

  writeback_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (wb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [4:0] rd,
                       input logic [1:0] sel, input logic [31:0] alu,
                       input logic [31:0] pc, input logic [31:0] ld, input logic [2:0] f3);
    wb_if.mem_valid      = v;
    wb_if.mem_reg_we     = we;
    wb_if.mem_rd_addr    = rd;
    wb_if.mem_wb_sel     = sel;
    wb_if.mem_alu_result = alu;
    wb_if.mem_pc         = pc;
    wb_if.mem_load_data  = ld;
    wb_if.mem_funct3     = f3;
  endtask

  task automatic expect_wb(input string tag, input logic v, input logic we,
                           input logic [4:0] rd, input logic [31:0] data,
                           input logic flt, input logic [31:0] ret);
    chk({tag, ".wb_valid"},     32'(wb_if.wb_valid),     32'(v));
    chk({tag, ".write_enable"}, 32'(wb_if.write_enable), 32'(we));
    chk({tag, ".addr_rd"},      32'(wb_if.addr_rd),      32'(rd));
    chk({tag, ".data_rd"},      wb_if.data_rd,           data);
    chk({tag, ".load_fault"},   32'(wb_if.load_fault),   32'(flt));
    chk({tag, ".retire_count"}, wb_if.retire_count,      ret);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    wb_if.stall = 1'b0;
    wb_if.flush = 1'b0;
    wb_if.dec_rs1_addr = 5'd7;
    wb_if.dec_rs2_addr = 5'd8;
    wb_if.rf_rs1_data  = 32'h0000_0007;
    wb_if.rf_rs2_data  = 32'h0000_0055;
    drive(1'b0, 1'b0, 5'd0, 2'b00, 32'd0, 32'd0, 32'd0, 3'd0);
    #2;
    expect_wb("reset", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;

    // ALU result
    drive(1'b1, 1'b1, 5'd3, 2'b00, 32'h1234_5678, 32'h0, 32'h0, 3'd0);
    step();
    expect_wb("alu", 1'b1, 1'b1, 5'd3, 32'h1234_5678, 1'b0, 32'd0);
    // LB offset 3
    drive(1'b1, 1'b1, 5'd4, 2'b01, 32'h0000_1003, 32'h0, 32'h80FF_7F01, 3'b000);
    step();
    expect_wb("lb", 1'b1, 1'b1, 5'd4, 32'hFFFF_FF80, 1'b0, 32'd1);
    // LBU offset 1
    drive(1'b1, 1'b1, 5'd4, 2'b01, 32'h0000_1001, 32'h0, 32'h80FF_7F01, 3'b100);
    step();
    expect_wb("lbu", 1'b1, 1'b1, 5'd4, 32'h0000_007F, 1'b0, 32'd2);
    // LH offset 2
    drive(1'b1, 1'b1, 5'd4, 2'b01, 32'h0000_1002, 32'h0, 32'h80FF_7F01, 3'b001);
    step();
    expect_wb("lh", 1'b1, 1'b1, 5'd4, 32'hFFFF_80FF, 1'b0, 32'd3);
    // LHU offset 0
    drive(1'b1, 1'b1, 5'd4, 2'b01, 32'h0000_1000, 32'h0, 32'h80FF_7F01, 3'b101);
    step();
    expect_wb("lhu", 1'b1, 1'b1, 5'd4, 32'h0000_7F01, 1'b0, 32'd4);
    // LW misaligned
    drive(1'b1, 1'b1, 5'd5, 2'b01, 32'h0000_1002, 32'h0, 32'h80FF_7F01, 3'b010);
    step();
    expect_wb("lw_mis", 1'b1, 1'b0, 5'd5, 32'd0, 1'b1, 32'd5);
    // x0 destination; faulted LW now counted
    drive(1'b1, 1'b1, 5'd0, 2'b00, 32'h0000_1234, 32'h0, 32'h0, 3'd0);
    step();
    expect_wb("x0", 1'b1, 1'b0, 5'd0, 32'h0000_1234, 1'b0, 32'd6);
    // PC+4 and its wrap
    drive(1'b1, 1'b1, 5'd1, 2'b10, 32'h0, 32'h0000_1000, 32'h0, 3'd0);
    step();
    expect_wb("pc4", 1'b1, 1'b1, 5'd1, 32'h0000_1004, 1'b0, 32'd7);
    drive(1'b1, 1'b1, 5'd1, 2'b10, 32'h0, 32'hFFFF_FFFC, 32'h0, 3'd0);
    step();
    expect_wb("pc4_wrap", 1'b1, 1'b1, 5'd1, 32'h0, 1'b0, 32'd8);
    // reserved select
    drive(1'b1, 1'b1, 5'd2, 2'b11, 32'hAAAA_5555, 32'h0, 32'h0, 3'd0);
    step();
    expect_wb("sel11", 1'b1, 1'b0, 5'd2, 32'h0, 1'b0, 32'd9);
    // LH odd offset, illegal funct3
    drive(1'b1, 1'b1, 5'd4, 2'b01, 32'h0000_1001, 32'h0, 32'h80FF_7F01, 3'b001);
    step();
    expect_wb("lh_mis", 1'b1, 1'b0, 5'd4, 32'h0, 1'b1, 32'd10);
    drive(1'b1, 1'b1, 5'd4, 2'b01, 32'h0000_1000, 32'h0, 32'h80FF_7F01, 3'b011);
    step();
    expect_wb("f3_011", 1'b1, 1'b0, 5'd4, 32'h0, 1'b1, 32'd11);
    // bypass
    drive(1'b1, 1'b1, 5'd7, 2'b00, 32'hDEAD_BEEF, 32'h0, 32'h0, 3'd0);
    step();
    expect_wb("byp", 1'b1, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, 32'd12);
`ifdef WB_BYPASS_EN
    chk("byp.fwd_rs1", wb_if.fwd_rs1_data, 32'hDEAD_BEEF);
`else
    chk("byp.fwd_rs1", wb_if.fwd_rs1_data, 32'h0000_0007);
`endif
    chk("byp.fwd_rs2", wb_if.fwd_rs2_data, 32'h0000_0055);

    // valid LW held by stall while MEM presents a different instruction
    drive(1'b1, 1'b1, 5'd9, 2'b01, 32'h0000_2000, 32'h0, 32'hCAFE_F00D, 3'b010);
    step();
    expect_wb("lw", 1'b1, 1'b1, 5'd9, 32'hCAFE_F00D, 1'b0, 32'd13);
    wb_if.stall = 1'b1;
    drive(1'b1, 1'b1, 5'd10, 2'b00, 32'h1111_2222, 32'h0, 32'h0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_wb($sformatf("stall%0d", i), 1'b1, 1'b1, 5'd9, 32'hCAFE_F00D, 1'b0, 32'd13);
    end
    chk("stall.fwd_rs1", wb_if.fwd_rs1_data, 32'h0000_0007);
    wb_if.flush = 1'b1;
    step();
    chk("flush.wb_valid", 32'(wb_if.wb_valid), 32'd0);
    chk("flush.write_enable", 32'(wb_if.write_enable), 32'd0);
    chk("flush.retire_count", wb_if.retire_count, 32'd13);
    wb_if.stall = 1'b0;
    wb_if.flush = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 3'd0);
    step();
    chk("idle.retire_count", wb_if.retire_count, 32'd13);

    // counter wrap: preload the terminal value directly
    force dut.retire_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_count_q;
    drive(1'b1, 1'b1, 5'd6, 2'b00, 32'h0000_AAAA, 32'h0, 32'h0, 3'd0);
    step();
    expect_wb("pre_wrap", 1'b1, 1'b1, 5'd6, 32'h0000_AAAA, 1'b0, 32'hFFFF_FFFF);
    drive(1'b0, 1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 3'd0);
    step();
    chk("wrap.retire_count", wb_if.retire_count, 32'd0);
    chk("wrap.wb_valid", 32'(wb_if.wb_valid), 32'd0);

    // async reset mid-stall
    drive(1'b1, 1'b1, 5'd6, 2'b00, 32'h0000_0055, 32'h0, 32'h0, 3'd0);
    step();
    wb_if.stall = 1'b1;
    step();
    expect_wb("held", 1'b1, 1'b1, 5'd6, 32'h0000_0055, 1'b0, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    expect_wb("async_rst", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    drive(1'b1, 1'b1, 5'd8, 2'b00, 32'h0000_0077, 32'h0, 32'h0, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_stall.wb_valid", 32'(wb_if.wb_valid), 32'd0);
    wb_if.stall = 1'b0;
    step();
    expect_wb("first_cap", 1'b1, 1'b1, 5'd8, 32'h0000_0077, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 3'd0);
    step();
    chk("post_rst.retire_count", wb_if.retire_count, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
